conv_engine_seq: RTL and testbench
==================================

Name: conv_engine_seq

Overview:
- Parametrised, sequential 2-D convolution engine; successor to the combinational ConvolutionUnit.
- Computes valid-mode cross-correlation (no kernel flip) of a runtime-sized image with a runtime-sized kernel.
- Uses one multiply-accumulate per clock and supports stride 1 or 2.
- Sits between the matrix-input front end and the result display/readout logic, with a start/busy/done handshake.

Parameters:
- MAX_IN_DIM, 5, maximum image rows/cols.
- MAX_K_DIM, 3, maximum kernel rows/cols.
- DATA_W, 8, unsigned element width of image and kernel.
- ACC_W, 16, unsigned accumulator/result element width.
- CYC_W, 10, cycleCount width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only in IDLE.
- stride2  in  1  0 = stride 1, 1 = stride 2; latched at accept.
- in_m, in_n  in  $clog2(MAX_IN_DIM+1)  image rows/cols.
- k_m, k_n  in  $clog2(MAX_K_DIM+1)  kernel rows/cols.
- inputImage  in  MAX_IN_DIM*MAX_IN_DIM*DATA_W  element (r,c) at bit (r*MAX_IN_DIM+c)*DATA_W.
- kernelMatrix  in  MAX_K_DIM*MAX_K_DIM*DATA_W  element (r,c) at bit (r*MAX_K_DIM+c)*DATA_W.
- out_m, out_n  out  $clog2(MAX_IN_DIM+1)  result dims.
- convResult  out  MAX_IN_DIM*MAX_IN_DIM*ACC_W  element (r,c) at bit (r*MAX_IN_DIM+c)*ACC_W; unused slots are 0.
- busy  out  1  high from accept through the final WRITE/CHECK state.
- valid  out  1  result is good; held until the next accept.
- done  out  1  one-cycle pulse at completion, including the error case.
- dim_error  out  1  held until the next accept.
- overflow  out  1  saturation occurred (see Optional Feature).
- cycleCount  out  CYC_W  cycles spent in CHECK+MAC+WRITE.

Behaviour:
- Reset (reset=0, async): all outputs 0, convResult 0, state IDLE. Reset mid-run aborts with no done pulse.
- States: IDLE, CHECK, MAC, WRITE, DONE.
- IDLE: start=1 latches all inputs and stride2. It also clears convResult, valid, dim_error, overflow, cycleCount and sets busy=1. Next state is CHECK. start in any other state is ignored.
- CHECK (1 cycle): error if any dim is 0, k_m>in_m, k_n>in_n, in dim>MAX_IN_DIM, or k dim>MAX_K_DIM.
  - Error -> dim_error=1, out dims 0, go DONE.
  - Else out_m=(in_m-k_m)/s+1 and out_n=(in_n-k_n)/s+1 (floor, s=1 or 2), clear acc, go MAC.
- MAC: one cycle per kernel tap, raster order (kr outer, kc inner). acc += img[orow*s+kr][ocol*s+kc]*k[kr][kc], product widened to ACC_W. After tap (k_m-1,k_n-1) go WRITE.
- WRITE (1 cycle): store acc at output (orow,ocol), clear acc, advance ocol then orow. After the last output go DONE, else MAC.
- DONE (1 cycle): done=1, busy=0, valid=!dim_error, return to IDLE.
- cycleCount increments in every CHECK/MAC/WRITE cycle and saturates at 2^CYC_W-1.
- Total cycles = 1 + out_m*out_n*(k_m*k_n+1).
- Outputs stay stable in IDLE. Back-to-back: start asserted in the DONE→IDLE cycle is accepted on the following edge.

Optional Feature:
- Macro CONV_SAT_EN.
- Defined: an accumulation exceeding 2^ACC_W-1 clamps acc to all-ones for the rest of that output element and sets overflow=1, sticky until the next accept.
- Undefined: arithmetic wraps modulo 2^ACC_W and overflow is tied 0.

Test Plan:
- 4x4 image 1..16 row-major, 2x2 all-ones kernel, stride 1 -> 3x3 result [14 18 22; 30 34 38; 46 50 54], valid=1, cycleCount=46, one done pulse.
- Same image and kernel, stride2=1 -> 2x2 result [14 22; 46 54], cycleCount=21, unused convResult slots 0.
- 2x2 image, 3x3 kernel -> dim_error=1, valid=0, out_m=out_n=0, cycleCount=1, done pulses once; k_m=0 gives the same response.
- 3x3 image all 255, 3x3 kernel all 255 -> without CONV_SAT_EN result 60937 and overflow=0; with CONV_SAT_EN result 65535 and overflow=1.
- reset=0 asserted mid-MAC -> all outputs 0 immediately, no done pulse; a new start then runs to the correct result.
- start pulsed while busy -> ignored, result unchanged; start in the cycle after DONE -> accepted, valid cleared at accept.

Source files
------------

// File: rtl/conv_engine_seq_if.sv
// ---------------------------------------------------------------------------
// conv_engine_seq_if
// Bus bundle between the matrix-input front end (master) and the sequential
// convolution engine (slave).
//
// Signals (widths follow the parameters):
//   start, stride2          request and stride select, driven by the master
//   in_m, in_n, k_m, k_n    image and kernel dimensions
//   inputImage              image, element (r,c) at bit (r*MAX_IN_DIM+c)*DATA_W
//   kernelMatrix            kernel, element (r,c) at bit (r*MAX_K_DIM+c)*DATA_W
//   out_m, out_n            result dimensions
//   convResult              result, element (r,c) at bit (r*MAX_IN_DIM+c)*ACC_W
//   busy, valid, done       handshake/status
//   dim_error, overflow     error/status flags
//   cycleCount              cycles spent in CHECK+MAC+WRITE
// ---------------------------------------------------------------------------
interface conv_engine_seq_if #(
  parameter int MAX_IN_DIM = 5,
  parameter int MAX_K_DIM  = 3,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 16,
  parameter int CYC_W      = 10
);
  localparam int IW = $clog2(MAX_IN_DIM + 1);
  localparam int KW = $clog2(MAX_K_DIM + 1);

  logic                                    start;
  logic                                    stride2;
  logic [IW-1:0]                           in_m;
  logic [IW-1:0]                           in_n;
  logic [KW-1:0]                           k_m;
  logic [KW-1:0]                           k_n;
  logic [MAX_IN_DIM*MAX_IN_DIM*DATA_W-1:0] inputImage;
  logic [MAX_K_DIM*MAX_K_DIM*DATA_W-1:0]   kernelMatrix;
  logic [IW-1:0]                           out_m;
  logic [IW-1:0]                           out_n;
  logic [MAX_IN_DIM*MAX_IN_DIM*ACC_W-1:0]  convResult;
  logic                                    busy;
  logic                                    valid;
  logic                                    done;
  logic                                    dim_error;
  logic                                    overflow;
  logic [CYC_W-1:0]                        cycleCount;

  modport master (
    output start, stride2, in_m, in_n, k_m, k_n, inputImage, kernelMatrix,
    input  out_m, out_n, convResult, busy, valid, done, dim_error, overflow,
           cycleCount
  );

  modport slave (
    input  start, stride2, in_m, in_n, k_m, k_n, inputImage, kernelMatrix,
    output out_m, out_n, convResult, busy, valid, done, dim_error, overflow,
           cycleCount
  );
endinterface

// File: rtl/conv_engine_seq.sv
// ---------------------------------------------------------------------------
// conv_engine_seq
// Sequential valid-mode 2-D cross-correlation (no kernel flip) of a
// runtime-sized image with a runtime-sized kernel, one multiply-accumulate
// per clock, stride 1 or 2.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset; aborts a run without a done pulse
//   bus    conv_engine_seq_if.slave: start/stride2/dims/image/kernel in,
//          out dims, convResult, busy/valid/done, dim_error, overflow,
//          cycleCount out (all outputs registered)
//
// Configuration macro:
//   CONV_SAT_EN  defined   -> accumulation saturates at all-ones and sets
//                             the sticky overflow flag
//                undefined -> accumulation wraps modulo 2^ACC_W, overflow 0
// ---------------------------------------------------------------------------
module conv_engine_seq #(
  parameter int MAX_IN_DIM = 5,
  parameter int MAX_K_DIM  = 3,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 16,
  parameter int CYC_W      = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  conv_engine_seq_if.slave     bus
);
  localparam int IW = $clog2(MAX_IN_DIM + 1);
  localparam int KW = $clog2(MAX_K_DIM + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_MAC   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t state_r;
  state_t state_s;

  // Job parameters latched at accept
  logic                                    stride2_r;
  logic [IW-1:0]                           in_m_r;
  logic [IW-1:0]                           in_n_r;
  logic [KW-1:0]                           k_m_r;
  logic [KW-1:0]                           k_n_r;
  logic [MAX_IN_DIM*MAX_IN_DIM*DATA_W-1:0] img_r;
  logic [MAX_K_DIM*MAX_K_DIM*DATA_W-1:0]   ker_r;

  // Walk counters and accumulator
  logic [IW-1:0]    orow_r;
  logic [IW-1:0]    ocol_r;
  logic [KW-1:0]    kr_r;
  logic [KW-1:0]    kc_r;
  logic [ACC_W-1:0] acc_r;

  // Registered outputs
  logic [IW-1:0]    out_m_r;
  logic [IW-1:0]    out_n_r;
  logic [ACC_W-1:0] res_r [MAX_IN_DIM][MAX_IN_DIM];
  logic             busy_r;
  logic             valid_r;
  logic             done_r;
  logic             dim_error_r;
  logic             overflow_r;
  logic [CYC_W-1:0] cycle_count_r;

  // Combinational helpers
  logic [DATA_W-1:0] img_a_s [MAX_IN_DIM][MAX_IN_DIM];
  logic [DATA_W-1:0] ker_a_s [MAX_K_DIM][MAX_K_DIM];
  logic [MAX_IN_DIM*MAX_IN_DIM*ACC_W-1:0] conv_result_s;
  logic              err_s;
  logic [IW-1:0]     diff_m_s;
  logic [IW-1:0]     diff_n_s;
  logic [IW-1:0]     om_s;
  logic [IW-1:0]     on_s;
  logic [IW-1:0]     row_s;
  logic [IW-1:0]     col_s;
  logic [ACC_W-1:0]  pix_w_s;
  logic [ACC_W-1:0]  ker_w_s;
  logic [ACC_W-1:0]  prod_s;
  logic [ACC_W-1:0]  acc_next_s;
  logic              ovf_s;
  logic              last_tap_s;
  logic              last_out_s;

  // Saturating increment of the cycle counter
  function automatic logic [CYC_W-1:0] cyc_inc(input logic [CYC_W-1:0] v);
    if (v == {CYC_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CYC_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Unpack latched image/kernel into 2-D arrays for addressing
  always_comb begin
    for (int r = 0; r < MAX_IN_DIM; r++) begin
      for (int c = 0; c < MAX_IN_DIM; c++) begin
        img_a_s[r][c] = img_r[(r*MAX_IN_DIM+c)*DATA_W +: DATA_W];
      end
    end
    for (int r = 0; r < MAX_K_DIM; r++) begin
      for (int c = 0; c < MAX_K_DIM; c++) begin
        ker_a_s[r][c] = ker_r[(r*MAX_K_DIM+c)*DATA_W +: DATA_W];
      end
    end
  end

  // Pack the result array onto the output bus
  always_comb begin
    conv_result_s = {(MAX_IN_DIM*MAX_IN_DIM*ACC_W){1'b0}};
    for (int r = 0; r < MAX_IN_DIM; r++) begin
      for (int c = 0; c < MAX_IN_DIM; c++) begin
        conv_result_s[(r*MAX_IN_DIM+c)*ACC_W +: ACC_W] = res_r[r][c];
      end
    end
  end

  // Dimension check and output-size calculation from the latched job
  always_comb begin
    err_s = (in_m_r == {IW{1'b0}}) || (in_n_r == {IW{1'b0}}) ||
            (k_m_r == {KW{1'b0}})  || (k_n_r == {KW{1'b0}})  ||
            (in_m_r > IW'(MAX_IN_DIM)) || (in_n_r > IW'(MAX_IN_DIM)) ||
            (k_m_r > KW'(MAX_K_DIM))   || (k_n_r > KW'(MAX_K_DIM))   ||
            (IW'(k_m_r) > in_m_r) || (IW'(k_n_r) > in_n_r);
    diff_m_s = in_m_r - IW'(k_m_r);
    diff_n_s = in_n_r - IW'(k_n_r);
    if (stride2_r) begin
      om_s = (diff_m_s >> 1) + IW'(1);
      on_s = (diff_n_s >> 1) + IW'(1);
    end else begin
      om_s = diff_m_s + IW'(1);
      on_s = diff_n_s + IW'(1);
    end
  end

  // Tap addressing, product and accumulation (wrap or saturate)
  always_comb begin
    if (stride2_r) begin
      row_s = {orow_r[IW-2:0], 1'b0} + IW'(kr_r);
      col_s = {ocol_r[IW-2:0], 1'b0} + IW'(kc_r);
    end else begin
      row_s = orow_r + IW'(kr_r);
      col_s = ocol_r + IW'(kc_r);
    end
    pix_w_s = ACC_W'(img_a_s[row_s][col_s]);
    ker_w_s = ACC_W'(ker_a_s[kr_r][kc_r]);
    prod_s  = pix_w_s * ker_w_s;
`ifdef CONV_SAT_EN
    begin
      logic [ACC_W:0] sum_v;
      sum_v = {1'b0, acc_r} + {1'b0, prod_s};
      if (sum_v[ACC_W]) begin
        acc_next_s = {ACC_W{1'b1}};
        ovf_s      = 1'b1;
      end else begin
        acc_next_s = sum_v[ACC_W-1:0];
        ovf_s      = 1'b0;
      end
    end
`else
    acc_next_s = acc_r + prod_s;
    ovf_s      = 1'b0;
`endif
  end

  // Last-tap / last-output detection
  always_comb begin
    last_tap_s = (kr_r == k_m_r - KW'(1)) && (kc_r == k_n_r - KW'(1));
    last_out_s = (orow_r == out_m_r - IW'(1)) && (ocol_r == out_n_r - IW'(1));
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_CHECK;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (err_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_MAC;
        end
      end
      ST_MAC: begin
        if (last_tap_s) begin
          state_s = ST_WRITE;
        end else begin
          state_s = ST_MAC;
        end
      end
      ST_WRITE: begin
        if (last_out_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_MAC;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath, walk counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stride2_r     <= 1'b0;
      in_m_r        <= {IW{1'b0}};
      in_n_r        <= {IW{1'b0}};
      k_m_r         <= {KW{1'b0}};
      k_n_r         <= {KW{1'b0}};
      img_r         <= {(MAX_IN_DIM*MAX_IN_DIM*DATA_W){1'b0}};
      ker_r         <= {(MAX_K_DIM*MAX_K_DIM*DATA_W){1'b0}};
      orow_r        <= {IW{1'b0}};
      ocol_r        <= {IW{1'b0}};
      kr_r          <= {KW{1'b0}};
      kc_r          <= {KW{1'b0}};
      acc_r         <= {ACC_W{1'b0}};
      out_m_r       <= {IW{1'b0}};
      out_n_r       <= {IW{1'b0}};
      busy_r        <= 1'b0;
      valid_r       <= 1'b0;
      done_r        <= 1'b0;
      dim_error_r   <= 1'b0;
      overflow_r    <= 1'b0;
      cycle_count_r <= {CYC_W{1'b0}};
      for (int r = 0; r < MAX_IN_DIM; r++) begin
        for (int c = 0; c < MAX_IN_DIM; c++) begin
          res_r[r][c] <= {ACC_W{1'b0}};
        end
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            stride2_r     <= bus.stride2;
            in_m_r        <= bus.in_m;
            in_n_r        <= bus.in_n;
            k_m_r         <= bus.k_m;
            k_n_r         <= bus.k_n;
            img_r         <= bus.inputImage;
            ker_r         <= bus.kernelMatrix;
            busy_r        <= 1'b1;
            valid_r       <= 1'b0;
            dim_error_r   <= 1'b0;
            overflow_r    <= 1'b0;
            cycle_count_r <= {CYC_W{1'b0}};
            for (int r = 0; r < MAX_IN_DIM; r++) begin
              for (int c = 0; c < MAX_IN_DIM; c++) begin
                res_r[r][c] <= {ACC_W{1'b0}};
              end
            end
          end
        end
        ST_CHECK: begin
          cycle_count_r <= cyc_inc(cycle_count_r);
          if (err_s) begin
            dim_error_r <= 1'b1;
            out_m_r     <= {IW{1'b0}};
            out_n_r     <= {IW{1'b0}};
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
            valid_r     <= 1'b0;
          end else begin
            out_m_r <= om_s;
            out_n_r <= on_s;
            acc_r   <= {ACC_W{1'b0}};
            orow_r  <= {IW{1'b0}};
            ocol_r  <= {IW{1'b0}};
            kr_r    <= {KW{1'b0}};
            kc_r    <= {KW{1'b0}};
          end
        end
        ST_MAC: begin
          cycle_count_r <= cyc_inc(cycle_count_r);
          acc_r         <= acc_next_s;
          if (ovf_s) begin
            overflow_r <= 1'b1;
          end
          // Raster walk over the kernel: kc inner, kr outer
          if (kc_r == k_n_r - KW'(1)) begin
            kc_r <= {KW{1'b0}};
            if (kr_r == k_m_r - KW'(1)) begin
              kr_r <= {KW{1'b0}};
            end else begin
              kr_r <= kr_r + KW'(1);
            end
          end else begin
            kc_r <= kc_r + KW'(1);
          end
        end
        ST_WRITE: begin
          cycle_count_r        <= cyc_inc(cycle_count_r);
          res_r[orow_r][ocol_r] <= acc_r;
          acc_r                <= {ACC_W{1'b0}};
          if (ocol_r == out_n_r - IW'(1)) begin
            ocol_r <= {IW{1'b0}};
            orow_r <= orow_r + IW'(1);
          end else begin
            ocol_r <= ocol_r + IW'(1);
          end
          if (last_out_s) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            valid_r <= ~dim_error_r;
          end
        end
        ST_DONE: begin
          done_r <= 1'b0;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_m      = out_m_r;
  assign bus.out_n      = out_n_r;
  assign bus.convResult = conv_result_s;
  assign bus.busy       = busy_r;
  assign bus.valid      = valid_r;
  assign bus.done       = done_r;
  assign bus.dim_error  = dim_error_r;
  assign bus.overflow   = overflow_r;
  assign bus.cycleCount = cycle_count_r;

endmodule

// File: tb/tb_conv_engine_seq.sv
// ---------------------------------------------------------------------------
// tb_conv_engine_seq
// Directed self-checking bench for conv_engine_seq with hand-computed
// expected results.
// ---------------------------------------------------------------------------
module tb_conv_engine_seq;
  localparam int MAX_IN_DIM = 5;
  localparam int MAX_K_DIM  = 3;
  localparam int DATA_W     = 8;
  localparam int ACC_W      = 16;
  localparam int CYC_W      = 10;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   done_cnt;
  int   exp_tab [9];

  conv_engine_seq_if #(
    .MAX_IN_DIM(MAX_IN_DIM), .MAX_K_DIM(MAX_K_DIM), .DATA_W(DATA_W),
    .ACC_W(ACC_W), .CYC_W(CYC_W)
  ) bus_if ();

  conv_engine_seq #(
    .MAX_IN_DIM(MAX_IN_DIM), .MAX_K_DIM(MAX_K_DIM), .DATA_W(DATA_W),
    .ACC_W(ACC_W), .CYC_W(CYC_W)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count done pulses, sampled away from the active edge
  always @(negedge clk) begin
    if (bus_if.done) done_cnt++;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // img_mode 0: r*in_n+c+1, img_mode 1: all 255; kernel filled with ker_val
  task automatic set_job(input int im, input int inn, input int km, input int kn,
                         input bit s2, input int img_mode, input int ker_val);
    bus_if.in_m    = 3'(im);
    bus_if.in_n    = 3'(inn);
    bus_if.k_m     = 2'(km);
    bus_if.k_n     = 2'(kn);
    bus_if.stride2 = s2;
    bus_if.inputImage   = '0;
    bus_if.kernelMatrix = '0;
    for (int r = 0; r < im && r < MAX_IN_DIM; r++)
      for (int c = 0; c < inn && c < MAX_IN_DIM; c++)
        bus_if.inputImage[(r*MAX_IN_DIM+c)*DATA_W +: DATA_W] =
          (img_mode == 0) ? 8'(r*inn+c+1) : 8'd255;
    for (int r = 0; r < km && r < MAX_K_DIM; r++)
      for (int c = 0; c < kn && c < MAX_K_DIM; c++)
        bus_if.kernelMatrix[(r*MAX_K_DIM+c)*DATA_W +: DATA_W] = 8'(ker_val);
  endtask

  task automatic pulse_start();
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!bus_if.done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " done_seen"}, longint'(bus_if.done), 1);
  endtask

  task automatic check_grid(input string tag, input int om, input int on);
    int e;
    for (int r = 0; r < MAX_IN_DIM; r++) begin
      for (int c = 0; c < MAX_IN_DIM; c++) begin
        e = (r < om && c < on) ? exp_tab[r*on+c] : 0;
        chk($sformatf("%s res[%0d][%0d]", tag, r, c),
            longint'(bus_if.convResult[(r*MAX_IN_DIM+c)*ACC_W +: ACC_W]), e);
      end
    end
  endtask

  task automatic check_status(input string tag, input int om, input int on,
                              input int vld, input int derr, input int ovf,
                              input int cyc);
    chk({tag, " out_m"},      longint'(bus_if.out_m), om);
    chk({tag, " out_n"},      longint'(bus_if.out_n), on);
    chk({tag, " valid"},      longint'(bus_if.valid), vld);
    chk({tag, " dim_error"},  longint'(bus_if.dim_error), derr);
    chk({tag, " overflow"},   longint'(bus_if.overflow), ovf);
    chk({tag, " cycleCount"}, longint'(bus_if.cycleCount), cyc);
    chk({tag, " busy"},       longint'(bus_if.busy), 0);
  endtask

  initial begin
    int base;
    n_checks = 0;
    n_errors = 0;
    done_cnt = 0;
    rst_n = 1'b0;
    bus_if.start = 1'b0;
    set_job(0, 0, 0, 0, 1'b0, 0, 0);
    repeat (3) @(negedge clk);

    // reset state
    chk("rst busy", longint'(bus_if.busy), 0);
    chk("rst valid", longint'(bus_if.valid), 0);
    chk("rst done", longint'(bus_if.done), 0);
    chk("rst cycleCount", longint'(bus_if.cycleCount), 0);
    chk("rst convResult", longint'(bus_if.convResult == '0), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // 4x4 ramp, 2x2 ones, stride 1
    exp_tab = '{14, 18, 22, 30, 34, 38, 46, 50, 54};
    set_job(4, 4, 2, 2, 1'b0, 0, 1);
    base = done_cnt;
    pulse_start();
    chk("s1 busy", longint'(bus_if.busy), 1);
    wait_done("s1");
    @(negedge clk);
    check_grid("s1", 3, 3);
    check_status("s1", 3, 3, 1, 0, 0, 46);
    chk("s1 done_pulses", done_cnt - base, 1);

    // same, stride 2
    exp_tab = '{14, 22, 46, 54, 0, 0, 0, 0, 0};
    set_job(4, 4, 2, 2, 1'b1, 0, 1);
    base = done_cnt;
    pulse_start();
    wait_done("s2");
    @(negedge clk);
    check_grid("s2", 2, 2);
    check_status("s2", 2, 2, 1, 0, 0, 21);
    chk("s2 done_pulses", done_cnt - base, 1);

    // kernel larger than image
    exp_tab = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    set_job(2, 2, 3, 3, 1'b0, 0, 1);
    base = done_cnt;
    pulse_start();
    wait_done("kbig");
    @(negedge clk);
    check_grid("kbig", 0, 0);
    check_status("kbig", 0, 0, 0, 1, 0, 1);
    chk("kbig done_pulses", done_cnt - base, 1);

    // zero kernel rows
    set_job(4, 4, 0, 2, 1'b0, 0, 1);
    base = done_cnt;
    pulse_start();
    wait_done("kzero");
    @(negedge clk);
    check_status("kzero", 0, 0, 0, 1, 0, 1);
    chk("kzero done_pulses", done_cnt - base, 1);

    // 3x3 of 255 with 3x3 of 255: wrap or saturate
`ifdef CONV_SAT_EN
    exp_tab = '{65535, 0, 0, 0, 0, 0, 0, 0, 0};
`else
    exp_tab = '{60937, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
    set_job(3, 3, 3, 3, 1'b0, 1, 255);
    pulse_start();
    wait_done("big");
    @(negedge clk);
    check_grid("big", 1, 1);
`ifdef CONV_SAT_EN
    check_status("big", 1, 1, 1, 0, 1, 11);
`else
    check_status("big", 1, 1, 1, 0, 0, 11);
`endif

    // reset in the middle of MAC
    exp_tab = '{14, 18, 22, 30, 34, 38, 46, 50, 54};
    set_job(4, 4, 2, 2, 1'b0, 0, 1);
    base = done_cnt;
    pulse_start();
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy", longint'(bus_if.busy), 0);
    chk("abort out_m", longint'(bus_if.out_m), 0);
    chk("abort cycleCount", longint'(bus_if.cycleCount), 0);
    chk("abort valid", longint'(bus_if.valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort no_done", done_cnt - base, 0);
    pulse_start();
    wait_done("rerun");
    @(negedge clk);
    check_grid("rerun", 3, 3);
    check_status("rerun", 3, 3, 1, 0, 0, 46);

    // start while busy is ignored, even with altered inputs
    set_job(4, 4, 2, 2, 1'b0, 0, 1);
    pulse_start();
    repeat (6) @(negedge clk);
    set_job(4, 4, 2, 2, 1'b1, 0, 2);
    pulse_start();
    wait_done("ign");
    check_grid("ign", 3, 3);
    chk("ign cycleCount", longint'(bus_if.cycleCount), 46);

    // back-to-back: start raised during DONE, held into IDLE
    exp_tab = '{14, 22, 46, 54, 0, 0, 0, 0, 0};
    set_job(4, 4, 2, 2, 1'b1, 0, 1);
    bus_if.start = 1'b1;
    @(negedge clk);
    chk("b2b idle valid", longint'(bus_if.valid), 1);
    chk("b2b idle busy", longint'(bus_if.busy), 0);
    @(negedge clk);
    bus_if.start = 1'b0;
    chk("b2b accept valid", longint'(bus_if.valid), 0);
    chk("b2b accept busy", longint'(bus_if.busy), 1);
    wait_done("b2b");
    @(negedge clk);
    check_grid("b2b", 2, 2);
    check_status("b2b", 2, 2, 1, 0, 0, 21);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
